// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI slave memory endpoint with independent write and read
// engines over a shared word array. Supports INCR bursts up to 256 beats,
// byte strobes, and OKAY/SLVERR/DECERR responses.
module axi_slave_mem #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // write address channel
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [ID_W-1:0]     AWID,
    input  logic [7:0]          AWLEN,
    // write data channel
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    // write response channel
    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    output logic [ID_W-1:0]     BID,
    // read address channel
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [ID_W-1:0]     ARID,
    input  logic [7:0]          ARLEN,
    // read data channel
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic [ID_W-1:0]     RID
);

    localparam int                STRB_W     = DATA_W / 8;
    localparam int                BYTE_SHIFT = $clog2(STRB_W);
    localparam int                IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   MEM_BYTES  = (ADDR_W+1)'(DEPTH * STRB_W);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // write engine state
    w_state_t          w_state;
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [1:0]        b_resp;
    logic [ID_W-1:0]   b_id;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len;
    logic [7:0]        w_beat;
    logic              w_slverr;
    logic              w_decerr;

    // write beat decode
    logic [ADDR_W:0]   w_off;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_fire;
    logic              w_final;
    logic              w_slverr_nx;
    logic              w_decerr_nx;

    // read engine state
    r_state_t          r_state;
    logic              ar_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;

    // read beat decode
    logic [ADDR_W-1:0] r_load_addr;
    logic [ADDR_W:0]   r_off;
    logic              r_in_range;
    logic [IDX_W-1:0]  r_idx;
    logic              r_start;
    logic              r_fire;
    logic [DATA_W-1:0] r_beat_data;
    logic [1:0]        r_beat_resp;

    // Decode the current write beat: range check (borrow bit catches addresses below base), word index and error accumulation
    always_comb begin
        w_off       = {1'b0, w_addr} - {1'b0, BASE_ADDR};
        w_in_range  = (w_off < MEM_BYTES);
        w_idx       = w_off[BYTE_SHIFT +: IDX_W];
        w_fire      = (w_state == W_DATA) && WVALID && w_ready;
        w_final     = (w_beat == w_len);
        w_slverr_nx = w_slverr | (WLAST != w_final);
        w_decerr_nx = w_decerr | ~w_in_range;
    end

    // Write engine: accept address, count beats by AWLEN, then hold the response until taken
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
            w_addr   <= '0;
            w_id     <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_ready && AWVALID) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        w_addr   <= AWADDR;
                        w_id     <= AWID;
                        w_len    <= AWLEN;
                        w_beat   <= '0;
                        w_slverr <= 1'b0;
                        w_decerr <= 1'b0;
                        w_state  <= W_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_slverr <= w_slverr_nx;
                        w_decerr <= w_decerr_nx;
                        if (w_final) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_id    <= w_id;
                            b_resp  <= w_decerr_nx ? RESP_DECERR :
                                       w_slverr_nx ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            w_addr <= w_addr + BEAT_BYTES;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        b_valid  <= 1'b0;
                        b_resp   <= RESP_OKAY;
                        b_id     <= '0;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Commit strobed bytes of in-range write beats; the array itself is never reset
    always_ff @(posedge ACLK) begin
        if (w_fire && w_in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) begin
                    mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    // Decode the next read beat: the burst start when idle, otherwise the following word
    always_comb begin
        r_load_addr = (r_state == R_IDLE) ? ARADDR : (r_addr + BEAT_BYTES);
        r_off       = {1'b0, r_load_addr} - {1'b0, BASE_ADDR};
        r_in_range  = (r_off < MEM_BYTES);
        r_idx       = r_off[BYTE_SHIFT +: IDX_W];
        r_start     = (r_state == R_IDLE) && ar_ready && ARVALID;
        r_fire      = (r_state == R_DATA) && r_valid && RREADY;
        r_beat_data = r_in_range ? mem[r_idx] : '0;
        r_beat_resp = r_in_range ? RESP_OKAY : RESP_DECERR;
    end

    // Read engine: load beat 0 on the AR handshake, then the next beat on each R handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_start) begin
                        ar_ready <= 1'b0;
                        r_addr   <= r_load_addr;
                        r_id     <= ARID;
                        r_len    <= ARLEN;
                        r_beat   <= '0;
                        r_valid  <= 1'b1;
                        r_data   <= r_beat_data;
                        r_resp   <= r_beat_resp;
                        r_last   <= (ARLEN == 8'd0);
                        r_state  <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_resp   <= RESP_OKAY;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_addr <= r_load_addr;
                            r_beat <= r_beat + 8'd1;
                            r_data <= r_beat_data;
                            r_resp <= r_beat_resp;
                            r_last <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = aw_ready;
    assign WREADY  = w_ready;
    assign BVALID  = b_valid;
    assign BRESP   = b_resp;
    assign BID     = b_id;
    assign ARREADY = ar_ready;
    assign RVALID  = r_valid;
    assign RDATA   = r_data;
    assign RRESP   = r_resp;
    assign RLAST   = r_last;
    assign RID     = r_id;

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
Parametrised AXI slave memory responder; successor to the fixed 32-bit single-beat master-side signal bundle. Adds INCR bursts (AxLEN), byte strobes, RRESP and configurable widths/depth. Write and read paths are independent FSMs over a shared word array. Serves as the endpoint behind the interconnect in block and system benches.

Parameters:
DATA_W, 32, data bus width in bits (32 or 64)
ADDR_W, 32, address width
ID_W, 4, transaction ID width
DEPTH, 256, memory depth in DATA_W words (power of 2)
BASE_ADDR, 0, byte address of word 0

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
AWVALID/AWREADY  in/out  1/1  write address handshake
AWADDR  in  ADDR_W  burst start byte address
AWID  in  ID_W  write ID
AWLEN  in  8  beats minus one
WVALID/WREADY  in/out  1/1  write data handshake
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte enables
WLAST  in  1  last write beat flag
BVALID/BREADY  out/in  1/1  write response handshake
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
BID  out  ID_W  echoed AWID
ARVALID/ARREADY  in/out  1/1  read address handshake
ARADDR  in  ADDR_W  burst start byte address
ARID  in  ID_W  read ID
ARLEN  in  8  beats minus one
RVALID/RREADY  out/in  1/1  read data handshake
RDATA  out  DATA_W  read data
RRESP  out  2  per-beat response
RLAST  out  1  final beat flag
RID  out  ID_W  echoed ARID

Behaviour:
- Reset (async assert, sync release): all READY/VALID, BRESP, BID, RDATA, RRESP, RLAST, RID = 0; both FSMs to IDLE; memory array not cleared. Reset mid-burst abandons the burst; no B/R is issued for it.
- Transfer occurs on rising edge with VALID&READY. Outputs are registered; VALID, once high, holds with stable payload until READY.
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake at cycle N latches AWADDR/AWID/AWLEN, clears beat counter and error flags -> W_DATA from N+1 (WREADY=1). Each beat writes bytes whose WSTRB bit is set. Phase ends on beat AWLEN+1 -> W_RESP, BVALID=1 next cycle -> B handshake -> W_IDLE (AWREADY=1 the following cycle).
- Write errors: WLAST must be high only on beat AWLEN+1; any mismatch sets SLVERR. Beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) is dropped and sets DECERR. BRESP priority: DECERR > SLVERR > OKAY.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake at N -> R_DATA, beat 0 valid at N+1. Next beat loads on the cycle after each R handshake; with RREADY held high, beats stream back-to-back. RLAST=1 on beat ARLEN. After the last handshake -> R_IDLE, ARREADY=1 next cycle.
- Read out-of-range beat: RDATA=0, RRESP=11; in-range beat: RRESP=00.
- Addressing: INCR only. Beat address = start + beat*(DATA_W/8); word index = (addr-BASE_ADDR)>>log2(DATA_W/8). Low unaligned address bits are ignored. 8-bit beat counter; ARLEN/AWLEN=255 gives 256 beats with no wrap.
- Same-cycle write and read-beat load to the same word: read returns old data; the write still commits.
- Write and read FSMs run concurrently; neither stalls the other.

Test Plan:
- AW{0x10,ID 3,LEN 0}, W{0xDEADBEEF,STRB F,LAST 1} -> BVALID cycle after W, BRESP 00, BID 3; AR 0x10 LEN 0 -> RDATA 0xDEADBEEF, RLAST 1, RRESP 00.
- 4-beat write at 0x20 then 4-beat read with RREADY toggled 1/0 -> data 0..3 in order, payload stable while stalled, RLAST only on beat 3.
- Write 0xFFFFFFFF, then WSTRB 0101 with 0x11223344 -> read returns 0xFF22FF44.
- AWLEN 3 with WLAST on beat 2 -> 4 beats accepted, BRESP 10; AR at BASE+DEPTH*4 -> RDATA 0, RRESP 11.
- Concurrent 8-beat write and read to disjoint regions -> both complete with no added stall; assert ARESETn mid-read -> RVALID 0 immediately, ARREADY 1 after release, no stale beats.
